// File: rtl/core2axi4l.sv
// core2axi4l: bridges an Ibex-style core_if request/grant/rvalid stream onto
// an AXI4-Lite master port, with a single transaction in flight at a time.
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   core_req_i/we_i/be_i/addr_i/wdata_i : core request side
//   core_gnt_o          : grant (the only combinational output)
//   core_rvalid_o/rdata_o/err_o         : one-cycle response to the core
//   axi_aw*/w*/b*       : AXI4-Lite write address, write data, write response
//   axi_ar*/r*          : AXI4-Lite read address, read data
//
// All AXI valid/ready outputs come straight from flops.
module core2axi4l #(
  parameter logic [2:0] AXI_PROT   = 3'b000,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // core side
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  // AXI4-Lite master side
  output logic                  axi_awvalid_o,
  output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
  output logic [2:0]            axi_awprot_o,
  input  logic                  axi_awready_i,
  output logic                  axi_wvalid_o,
  output logic [31:0]           axi_wdata_o,
  output logic [3:0]            axi_wstrb_o,
  input  logic                  axi_wready_i,
  input  logic                  axi_bvalid_i,
  input  logic [1:0]            axi_bresp_i,
  output logic                  axi_bready_o,
  output logic                  axi_arvalid_o,
  output logic [ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [2:0]            axi_arprot_o,
  input  logic                  axi_arready_i,
  input  logic                  axi_rvalid_i,
  input  logic [31:0]           axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  output logic                  axi_rready_o
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, WR, WR_B, RD_A, RD_R, RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;

  logic                    aw_fire, w_fire;

  assign core_gnt_o = core_req_i && (state_q == IDLE);

  assign aw_fire = awvalid_q && axi_awready_i;
  assign w_fire  = wvalid_q && axi_wready_i;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;

    unique case (state_q)
      IDLE: begin
        if (core_gnt_o) begin
          addr_d    = core_addr_i;
          wdata_d   = core_wdata_i;
          be_d      = core_be_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (core_we_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; each valid drops after its own
        // handshake and the done flags remember which side has finished.
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (axi_bvalid_i && bready_q) begin
          bready_d = 1'b0;
          err_d    = (axi_bresp_i != RESP_OKAY);
          rdata_d  = 32'h0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RD_A: begin
        if (arvalid_q && axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (axi_rvalid_i && rready_q) begin
          rready_d = 1'b0;
          rdata_d  = axi_rdata_i;
          err_d    = (axi_rresp_i != RESP_OKAY);
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        // rvalid_q is high for this one cycle only; the default clears it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;

  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awprot_o  = AXI_PROT;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = be_q;
  assign axi_bready_o  = bready_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arprot_o  = AXI_PROT;
  assign axi_rready_o  = rready_q;

endmodule
